adc5g_3wire_slave: RTL and testbench



---
 rtl/adc5g_3wire_pkg.sv | 27 ++
 rtl/adc5g_3wire_if.sv | 26 ++
 rtl/adc5g_sync_edge.sv | 37 +++
 rtl/adc5g_3wire_slave.sv | 126 ++++++++++++
 tb/tb_adc5g_3wire_slave.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/adc5g_3wire_pkg.sv
// Shared types and frame layout for the ADC5G 3-wire configuration slave.
// Frame (MSB first): header[31:20] | addr[19:16] | data[15:0].
package adc5g_3wire_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam int               FRAME_BITS_DEF = 32;
   localparam logic [11:0]      HEADER_DEF     = 12'h001;

   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 16;
   localparam int HDR_W    = 12;
   localparam int SHIFT_W  = 32;

   localparam int DATA_LSB = 0;
   localparam int ADDR_LSB = 16;
   localparam int HDR_LSB  = 20;

   // Bit counter saturates one past a full frame so long frames stay distinguishable.
   localparam int CNT_W    = 6;
   localparam int CNT_SAT  = 33;

endpackage

// File: rtl/adc5g_3wire_if.sv
// Serial link plus register-file side signals of the ADC5G 3-wire slave.
interface adc5g_3wire_if;
   import adc5g_3wire_pkg::*;

   logic              adc3wire_clk;
   logic              adc3wire_data;
   logic              adc3wire_strobe;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              frame_err;
   logic              busy;

   modport master (
      output adc3wire_clk, adc3wire_data, adc3wire_strobe, rd_addr,
      input  rd_data, wr_valid, wr_addr, wr_data, frame_err, busy
   );

   modport slave (
      input  adc3wire_clk, adc3wire_data, adc3wire_strobe, rd_addr,
      output rd_data, wr_valid, wr_addr, wr_data, frame_err, busy
   );

endinterface

// File: rtl/adc5g_sync_edge.sv
// STAGES-deep synchroniser for one edge-detected input plus LVL_W level-only inputs.
// The rising edge compares the current and previous synchronised samples.
module adc5g_sync_edge #(
   parameter int             STAGES  = 2,
   parameter int             LVL_W   = 2,
   parameter logic [LVL_W:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             edge_d,
   input  logic [LVL_W-1:0] lvl_d,
   output logic             edge_rise,
   output logic [LVL_W-1:0] lvl_q
);

   logic [LVL_W:0] sync_p [STAGES];
   logic           edge_prev_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_p[i] <= RST_VAL;
         end
         edge_prev_p <= RST_VAL[0];
      end else begin
         sync_p[0] <= {lvl_d, edge_d};
         for (int i = 1; i < STAGES; i++) begin
            sync_p[i] <= sync_p[i-1];
         end
         edge_prev_p <= sync_p[STAGES-1][0];
      end
   end

   assign lvl_q     = sync_p[STAGES-1][LVL_W:1];
   assign edge_rise = sync_p[STAGES-1][0] & ~edge_prev_p;

endmodule

// File: rtl/adc5g_3wire_slave.sv
// ADC5G 3-wire configuration slave: deserialises 32-bit frames into a 16x16 regfile.
// Define ADC5G_3WIRE_HEADER_CHECK_EN to also require header == HEADER_VAL for a commit.
module adc5g_3wire_slave
   import adc5g_3wire_pkg::*;
#(
   parameter int               SYNC_STAGES = 2,
   parameter int               FRAME_BITS  = FRAME_BITS_DEF,
   parameter logic [HDR_W-1:0] HEADER_VAL  = HEADER_DEF
) (
   input  logic          OPB_Clk,
   input  logic          OPB_Rst_n,
   adc5g_3wire_if.slave  bus
);

`ifdef ADC5G_3WIRE_HEADER_CHECK_EN
   localparam bit HDR_CHECK = 1'b1;
`else
   localparam bit HDR_CHECK = 1'b0;
`endif

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [SHIFT_W-1:0] shift, shift_nxt;
   logic               commit_nxt, reject_nxt;
   logic               clk_rise, strobe_s, data_s;
   logic               wr_valid_q, frame_err_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic [DATA_W-1:0]  regfile [1<<ADDR_W];

   function automatic logic frame_ok(input logic [CNT_W-1:0] c, input logic [HDR_W-1:0] hdr);
      return (c == CNT_W'(FRAME_BITS)) && (!HDR_CHECK || (hdr == HEADER_VAL));
   endfunction

   // Strobe resets high so the idle link does not look like a frame start.
   adc5g_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .LVL_W   (2),
      .RST_VAL (3'b100)
   ) u_sync (
      .clk       (OPB_Clk),
      .rst_n     (OPB_Rst_n),
      .edge_d    (bus.adc3wire_clk),
      .lvl_d     ({bus.adc3wire_strobe, bus.adc3wire_data}),
      .edge_rise (clk_rise),
      .lvl_q     ({strobe_s, data_s})
   );

   // The commit decision uses the post-shift values so a final edge coincident
   // with the strobe rise is still counted.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      shift_nxt  = shift;
      commit_nxt = 1'b0;
      reject_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (!strobe_s) begin
               state_nxt = SHIFT;
               cnt_nxt   = '0;
               shift_nxt = '0;
            end
         end
         SHIFT: begin
            if (clk_rise) begin
               shift_nxt = {shift[SHIFT_W-2:0], data_s};
               if (cnt != CNT_W'(CNT_SAT)) begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            if (strobe_s) begin
               state_nxt = CHECK;
               if (frame_ok(cnt_nxt, shift_nxt[HDR_LSB +: HDR_W])) begin
                  commit_nxt = 1'b1;
               end else begin
                  reject_nxt = 1'b1;
               end
            end
         end
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         shift       <= '0;
         wr_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         shift       <= shift_nxt;
         wr_valid_q  <= commit_nxt;
         frame_err_q <= reject_nxt;
         if (commit_nxt) begin
            wr_addr_q <= shift_nxt[ADDR_LSB +: ADDR_W];
            wr_data_q <= shift_nxt[DATA_LSB +: DATA_W];
         end
      end
   end

   // Regfile updates at the end of CHECK, so reads during CHECK still see the old value.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         for (int i = 0; i < (1<<ADDR_W); i++) begin
            regfile[i] <= '0;
         end
      end else if (state == CHECK && wr_valid_q) begin
         regfile[wr_addr_q] <= wr_data_q;
      end
   end

   assign bus.rd_data   = regfile[bus.rd_addr];
   assign bus.wr_valid  = wr_valid_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = (state == SHIFT);

endmodule

// File: tb/tb_adc5g_3wire_slave.sv
// Self-checking bench for adc5g_3wire_slave: table of frames plus hand-written
// sequences, with expected commit/reject events queued and checked on each pulse.
module tb_adc5g_3wire_slave;

`ifdef ADC5G_3WIRE_HEADER_CHECK_EN
   localparam bit HDR_CHK = 1'b1;
`else
   localparam bit HDR_CHK = 1'b0;
`endif

   typedef struct {
      logic [31:0] frame;
      int          nbits;
      bit          exp_wr;
   } vec_t;

   typedef struct {
      bit          is_wr;
      logic [3:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic        OPB_Clk;
   logic        OPB_Rst_n;
   int          n_checks;
   int          n_fail;
   exp_t        exp_q[$];
   logic [15:0] model [16];
   vec_t        vecs [7];

   adc5g_3wire_if bus();

   adc5g_3wire_slave dut (
      .OPB_Clk   (OPB_Clk),
      .OPB_Rst_n (OPB_Rst_n),
      .bus       (bus)
   );

   initial OPB_Clk = 1'b0;
   always #5 OPB_Clk = ~OPB_Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge OPB_Clk);
      #1;
   endtask

   task automatic push_wr(input logic [31:0] frame);
      exp_t e;
      e.is_wr = 1'b1;
      e.addr  = frame[19:16];
      e.data  = frame[15:0];
      exp_q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_wr = 1'b0;
      e.addr  = 4'h0;
      e.data  = 16'h0;
      exp_q.push_back(e);
   endtask

   // Serial clock at OPB_Clk/16; data changes while the serial clock is low.
   task automatic send_frame(input logic [31:0] frame, input int n, input int gap);
      bus.rd_addr         = frame[19:16];
      bus.adc3wire_strobe = 1'b0;
      cyc(8);
      for (int i = 0; i < n; i++) begin
         bus.adc3wire_data = (i < 32) ? frame[31-i] : 1'b0;
         cyc(8);
         if (i == 0) chk("busy_in_frame", {31'b0, bus.busy}, 32'd1);
         bus.adc3wire_clk = 1'b1;
         cyc(8);
         bus.adc3wire_clk = 1'b0;
      end
      cyc(8);
      bus.adc3wire_strobe = 1'b1;
      cyc(gap);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         cyc(1);
         t++;
      end
      chk("event_drain", exp_q.size(), 32'd0);
      cyc(4);
   endtask

   task automatic check_regs();
      for (int a = 0; a < 16; a++) begin
         bus.rd_addr = 4'(a);
         #1;
         chk($sformatf("rd_data[%0d]", a), {16'b0, bus.rd_data}, {16'b0, model[a]});
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int a = 0; a < 16; a++) model[a] = 16'h0000;

      vecs[0] = '{32'h0013BEEF, 32, 1'b1};
      vecs[1] = '{32'h00141111, 31, 1'b0};
      vecs[2] = '{32'h00142222, 33, 1'b0};
      vecs[3] = '{32'h00263333, 32, !HDR_CHK};
      vecs[4] = '{32'h0019FFFF, 32, 1'b1};
      vecs[5] = '{32'h00100042, 32, 1'b1};
      vecs[6] = '{32'h0013CAFE, 32, 1'b1};

      // Event monitor: each wr_valid/frame_err pulse must match the next expectation.
      fork
         forever begin
            @(negedge OPB_Clk);
            if (bus.wr_valid || bus.frame_err) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_pulse", {30'b0, bus.wr_valid, bus.frame_err}, 32'd0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("wr_valid", {31'b0, bus.wr_valid}, {31'b0, e.is_wr});
                  chk("frame_err", {31'b0, bus.frame_err}, {31'b0, !e.is_wr});
                  if (e.is_wr) begin
                     chk("wr_addr", {28'b0, bus.wr_addr}, {28'b0, e.addr});
                     chk("wr_data", {16'b0, bus.wr_data}, {16'b0, e.data});
                     if (bus.rd_addr == e.addr)
                        chk("rd_old_in_check", {16'b0, bus.rd_data}, {16'b0, model[e.addr]});
                     model[e.addr] = e.data;
                  end
               end
            end
         end
      join_none

      OPB_Rst_n           = 1'b0;
      bus.adc3wire_clk    = 1'b0;
      bus.adc3wire_data   = 1'b0;
      bus.adc3wire_strobe = 1'b1;
      bus.rd_addr         = 4'h0;
      cyc(3);
      OPB_Rst_n = 1'b1;
      cyc(3);
      chk("rst_wr_valid", {31'b0, bus.wr_valid}, 32'd0);
      chk("rst_frame_err", {31'b0, bus.frame_err}, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_wr_addr", {28'b0, bus.wr_addr}, 32'd0);
      chk("rst_wr_data", {16'b0, bus.wr_data}, 32'd0);
      check_regs();

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].exp_wr) push_wr(vecs[v].frame);
         else                push_err();
         send_frame(vecs[v].frame, vecs[v].nbits, 4);
         wait_idle();
         check_regs();
      end

      // Serial clock activity with strobe high must be ignored.
      for (int i = 0; i < 8; i++) begin
         bus.adc3wire_data = 1'($urandom_range(0, 1));
         bus.adc3wire_clk  = 1'b1;
         cyc(8);
         bus.adc3wire_clk  = 1'b0;
         cyc(8);
      end
      chk("idle_toggle_no_event", exp_q.size(), 32'd0);
      push_wr(32'h001F1234);
      send_frame(32'h001F1234, 32, 4);
      wait_idle();
      check_regs();

      // Reset mid-frame: discard partial frame, clear regfile, then truncated frame rejected.
      bus.rd_addr         = 4'h5;
      bus.adc3wire_strobe = 1'b0;
      cyc(8);
      for (int i = 0; i < 10; i++) begin
         bus.adc3wire_data = i[0];
         cyc(8);
         bus.adc3wire_clk = 1'b1;
         cyc(8);
         bus.adc3wire_clk = 1'b0;
      end
      chk("busy_before_rst", {31'b0, bus.busy}, 32'd1);
      OPB_Rst_n = 1'b0;
      #1;
      chk("busy_in_rst", {31'b0, bus.busy}, 32'd0);
      chk("wr_valid_in_rst", {31'b0, bus.wr_valid}, 32'd0);
      for (int a = 0; a < 16; a++) model[a] = 16'h0000;
      cyc(3);
      OPB_Rst_n = 1'b1;
      cyc(6);
      chk("busy_after_rst_strobe_low", {31'b0, bus.busy}, 32'd1);
      push_err();
      cyc(8);
      bus.adc3wire_strobe = 1'b1;
      wait_idle();
      check_regs();
      push_wr(32'h0015A5A5);
      send_frame(32'h0015A5A5, 32, 4);
      wait_idle();
      check_regs();

      // Back-to-back frames with a 2-cycle strobe-high gap.
      push_wr(32'h00120001);
      push_wr(32'h00120002);
      send_frame(32'h00120001, 32, 2);
      send_frame(32'h00120002, 32, 4);
      wait_idle();
      check_regs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
